// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared types and AXI constants for the stream-to-AXI write burst master.
package axi_wr_pkg;
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic logic [2:0] awsize_f(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/wr_burst_fifo.sv
// wr_burst_fifo: first-word-fall-through FIFO with occupancy count, full and empty flags.
module wr_burst_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 512,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic push_ok, pop_ok;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push_ok);
      rd_q <= rd_q + PW'(pop_ok);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/axi4_stream_wr_burst_master.sv
// axi4_stream_wr_burst_master: buffers a framed beat stream and writes it out as
// single-outstanding AXI4 INCR bursts starting from a per-frame base address.
module axi4_stream_wr_burst_master
  import axi_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH = 4,
  parameter int BURST_LEN = 64,
  parameter int FRAME_BEATS = 8100,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_INC = 8,
  parameter int AXI_ID = 0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   frame_base_addr,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic                    busy,
  output logic                    resp_err,
  output logic                    frame_short
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FRAME_BEATS + 1);
  localparam int LW = 9;
  state_t state_q, state_d;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  logic [FW-1:0] frame_cnt_q;
  logic [ADDR_WIDTH-1:0] next_addr_q, awaddr_q;
  logic [7:0] awlen_q, beat_cnt_q;
  logic [LW-1:0] len_q, len_d;
  logic awvalid_q, resp_err_q, frame_short_q;
  logic push, sof_acc, tail, full_burst, start, aw_hs, w_hs, w_done, b_done;
  logic unused_bid;
  assign unused_bid = ^axi_bid;
  // A new frame may only enter once the previous one has fully drained.
  assign in_ready = !fifo_full && !(in_sof && (state_q != IDLE || fifo_count != '0));
  assign push = in_valid && in_ready;
  assign sof_acc = push && in_sof;
  assign tail = frame_cnt_q == FW'(FRAME_BEATS) || (in_valid && in_sof && !in_ready);
  assign full_burst = fifo_count >= CW'(BURST_LEN);
  assign start = full_burst || (tail && fifo_count != '0);
  assign len_d = full_burst ? LW'(BURST_LEN) : LW'(fifo_count);
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs = axi_wvalid && axi_wready;
  assign w_done = w_hs && axi_wlast;
  assign b_done = axi_bvalid && axi_bready;
  wr_burst_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (w_hs),
    .data_o  (axi_wdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && start) ? AW :
              (state_q == AW && aw_hs) ? W :
              (state_q == W && w_done) ? B :
              (state_q == B && b_done) ? IDLE : state_q;
  end
  always_comb begin
    axi_wvalid = state_q == W && !fifo_empty;
    axi_wlast = state_q == W && beat_cnt_q == awlen_q;
    axi_bready = state_q == B;
    busy = state_q != IDLE || !fifo_empty;
  end
  assign axi_awid = ID_WIDTH'(AXI_ID);
  assign axi_awsize = awsize_f(DATA_WIDTH);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wstrb = '1;
  assign axi_awaddr = awaddr_q;
  assign axi_awlen = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign resp_err = resp_err_q;
  assign frame_short = frame_short_q;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      awaddr_q <= '0;
      awlen_q <= '0;
      len_q <= '0;
      beat_cnt_q <= '0;
      next_addr_q <= '0;
      frame_cnt_q <= '0;
      frame_short_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      awvalid_q <= state_d == AW;
      if (state_q == IDLE && start) begin
        awaddr_q <= next_addr_q;
        awlen_q <= 8'(len_d - 1'b1);
        len_q <= len_d;
      end
      beat_cnt_q <= state_q != W ? '0 : w_hs ? beat_cnt_q + 8'd1 : beat_cnt_q;
      if (b_done) next_addr_q <= next_addr_q + ADDR_WIDTH'(len_q * ADDR_INC);
      else if (sof_acc) next_addr_q <= frame_base_addr;
      frame_cnt_q <= sof_acc ? FW'(1) :
                     (push && frame_cnt_q != FW'(FRAME_BEATS)) ? frame_cnt_q + 1'b1 : frame_cnt_q;
      frame_short_q <= sof_acc && frame_cnt_q != '0 && frame_cnt_q != FW'(FRAME_BEATS);
      resp_err_q <= b_done && axi_bresp != AXI_RESP_OKAY;
    end
  end
endmodule

// File: tb/tb_axi4_stream_wr_burst_master.sv
// tb_axi4_stream_wr_burst_master: frame table driven through the stream port, with
// AW/data scoreboards checked by a bus responder, plus reset-state and mid-burst reset sequences.
module tb_axi4_stream_wr_burst_master;
  typedef struct packed {
    logic [26:0] base;
    logic [8:0]  nbeats;
    logic [3:0]  aw_delay;
    logic        wr_rand;
    logic        err;
    logic        exp_short;
  } row_t;
  typedef struct {
    logic [26:0] addr;
    logic [7:0]  len;
  } aw_t;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic [26:0] frame_base_addr = '0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_ready;
  logic [255:0] in_data = '0;
  logic [3:0] axi_awid;
  logic [26:0] axi_awaddr;
  logic [7:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid, axi_awready = 1'b0;
  logic [255:0] axi_wdata;
  logic [31:0] axi_wstrb;
  logic axi_wlast, axi_wvalid, axi_wready = 1'b0;
  logic [3:0] axi_bid = '0;
  logic [1:0] axi_bresp = '0;
  logic axi_bvalid = 1'b0, axi_bready;
  logic busy, resp_err, frame_short;
  int n_vec = 0, n_err = 0;
  aw_t aw_q[$];
  logic [255:0] data_q[$];
  int aw_delay = 0;
  bit wr_rand = 0, err_pending = 0;
  int aw_wait = 0, cur_len = 0, beat_idx = 0, b_cnt = 0, exp_b_total = 0;
  bit err_chk = 0, err_exp = 0;
  row_t rows[7];
  always #5 clock = ~clock;
  axi4_stream_wr_burst_master #(.FRAME_BEATS(128)) dut (
    .clock(clock), .rst(rst), .frame_base_addr(frame_base_addr),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_ready(in_ready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .busy(busy), .resp_err(resp_err), .frame_short(frame_short)
  );
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask
  // Bus responder: decides ready/valid each negedge, so handshakes land on the next posedge.
  initial forever begin
    @(negedge clock);
    if (rst) begin
      axi_awready = 0;
      axi_wready = 0;
      axi_bvalid = 0;
      aw_wait = 0;
      beat_idx = 0;
      err_chk = 0;
    end else begin
      if (err_chk) begin
        chk("resp_err", resp_err, err_exp);
        err_chk = 0;
      end
      if (axi_awvalid) begin
        chk("w_before_aw", axi_wvalid, 0);
        if (aw_q.size() == 0) begin
          fail_now("unexpected_aw");
          axi_awready = 1;
        end else begin
          chk("awaddr", axi_awaddr, aw_q[0].addr);
          chk("awlen", axi_awlen, aw_q[0].len);
          if (aw_wait < aw_delay) begin
            axi_awready = 0;
            aw_wait++;
          end else begin
            axi_awready = 1;
            cur_len = int'(aw_q[0].len) + 1;
            void'(aw_q.pop_front());
            beat_idx = 0;
            aw_wait = 0;
          end
        end
      end else begin
        axi_awready = 0;
        if (aw_wait != 0) begin
          fail_now("awvalid_dropped");
          aw_wait = 0;
        end
      end
      if (axi_wvalid) begin
        axi_wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (axi_wready) begin
          if (data_q.size() == 0) fail_now("unexpected_w");
          else chk("wdata", axi_wdata, data_q.pop_front());
          chk("wlast", axi_wlast, beat_idx == cur_len - 1);
          beat_idx++;
        end
      end else axi_wready = 0;
      if (axi_bready) begin
        axi_bvalid = 1;
        axi_bresp = err_pending ? 2'b10 : 2'b00;
        err_exp = err_pending;
        err_pending = 0;
        err_chk = 1;
        b_cnt++;
        chk("beats_per_burst", beat_idx, cur_len);
      end else axi_bvalid = 0;
    end
  end
  task automatic send_beat(input logic sof, input logic [255:0] d, output bit ok);
    int n = 0;
    in_valid = 1;
    in_sof = sof;
    in_data = d;
    ok = 0;
    while (!ok && n < 4000) begin
      #1;
      ok = in_ready;
      @(negedge clock);
      n++;
    end
    in_valid = 0;
    in_sof = 0;
  endtask
  task automatic send_frame(input row_t r);
    logic [255:0] d;
    bit ok;
    aw_t e;
    int left;
    frame_base_addr = r.base;
    for (int j = 0; j < int'(r.nbeats); j++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_beat(j == 0, d, ok);
      if (!ok) begin
        fail_now("in_accept_timeout");
        return;
      end
      data_q.push_back(d);
      if (j == 0) begin
        chk("frame_short", frame_short, r.exp_short);
        chk("sof_after_flush", b_cnt, exp_b_total);
        left = int'(r.nbeats);
        for (int k = 0; left > 0; k++) begin
          e.addr = r.base + 27'(k * 512);
          e.len = 8'((left > 64 ? 64 : left) - 1);
          aw_q.push_back(e);
          left -= 64;
          exp_b_total++;
        end
        aw_delay = int'(r.aw_delay);
        wr_rand = r.wr_rand;
        err_pending = r.err;
      end
      if (j == 1) chk("frame_short_pulse_end", frame_short, 0);
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((busy || aw_q.size() != 0 || data_q.size() != 0) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_aw_q", aw_q.size(), 0);
    chk("drain_data_q", data_q.size(), 0);
    chk("drain_b_cnt", b_cnt, exp_b_total);
    repeat (2) @(negedge clock);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rows[0] = '{27'h1000, 9'd128, 4'd0, 1'b0, 1'b0, 1'b0};
    rows[1] = '{27'h1000, 9'd100, 4'd0, 1'b0, 1'b0, 1'b0};
    rows[2] = '{27'h2000, 9'd128, 4'd0, 1'b0, 1'b0, 1'b1};
    rows[3] = '{27'h3000, 9'd128, 4'd5, 1'b0, 1'b0, 1'b0};
    rows[4] = '{27'h4000, 9'd64,  4'd0, 1'b1, 1'b0, 1'b0};
    rows[5] = '{27'h5000, 9'd128, 4'd0, 1'b0, 1'b1, 1'b1};
    rows[6] = '{27'h7FFFE00, 9'd128, 4'd2, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clock);
    rst = 0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wlast", axi_wlast, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_frame_short", frame_short, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_awlen", axi_awlen, 0);
    chk("awid", axi_awid, 0);
    chk("awsize", axi_awsize, 3'd5);
    chk("awburst", axi_awburst, 2'b01);
    chk("wstrb", axi_wstrb, 32'hFFFF_FFFF);
    for (int i = 0; i < 7; i++) send_frame(rows[i]);
    drain();
    send_frame('{27'h6000, 9'd64, 4'd0, 1'b0, 1'b0, 1'b0});
    for (int n = 0; beat_idx != 20 && n < 2000; n++) begin
      @(negedge clock);
      #2;
    end
    chk("reset_reach_beat20", beat_idx, 20);
    rst = 1;
    @(negedge clock);
    #2;
    chk("midrst_awvalid", axi_awvalid, 0);
    chk("midrst_wvalid", axi_wvalid, 0);
    chk("midrst_bready", axi_bready, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    aw_q.delete();
    data_q.delete();
    exp_b_total--;
    @(negedge clock);
    rst = 0;
    @(negedge clock);
    send_frame('{27'h0AB000, 9'd128, 4'd1, 1'b0, 1'b0, 1'b0});
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_stream_wr_burst_master.md
Name: axi4_stream_wr_burst_master

Overview:
- Upstream write-side feeder for the AXI4-to-DDR-native bridge.
- Accepts a video/pixel beat stream with start-of-frame markers and buffers it in an internal FIFO.
- Issues AXI4 INCR write bursts (AW/W/B) into the bridge, one transaction outstanding at a time.
- Writes each frame linearly from a programmable base address in DDR-native address units.

Parameters:
- ADDR_WIDTH, 27, width of awaddr and frame_base_addr (DDR native address units).
- DATA_WIDTH, 256, beat width of stream and W channel.
- ID_WIDTH, 4, awid/bid width.
- BURST_LEN, 64, maximum beats per burst (1..256).
- FRAME_BEATS, 8100, beats per complete frame.
- FIFO_DEPTH, 512, data FIFO depth in beats (power of two, ≥ 2*BURST_LEN).
- ADDR_INC, 8, address increment per beat (native units).
- AXI_ID, 0, constant awid value.

Ports:
- clock, in, 1, clock.
- rst, in, 1, reset.
- frame_base_addr, in, ADDR_WIDTH, frame start address; sampled on the accepted sof beat.
- in_valid, in, 1, stream beat valid.
- in_sof, in, 1, first beat of frame; qualified by in_valid.
- in_data, in, DATA_WIDTH, stream beat.
- in_ready, out, 1, stream accept.
- axi_awid, out, ID_WIDTH, = AXI_ID.
- axi_awaddr, out, ADDR_WIDTH, burst start address.
- axi_awlen, out, 8, beats-1.
- axi_awsize, out, 3, log2(DATA_WIDTH/8).
- axi_awburst, out, 2, 2'b01 (INCR).
- axi_awvalid, in/out pair: axi_awvalid out 1, axi_awready in 1.
- axi_wdata, out, DATA_WIDTH, write data.
- axi_wstrb, out, DATA_WIDTH/8, all ones.
- axi_wlast, out, 1, last beat of burst.
- axi_wvalid, out, 1; axi_wready, in, 1.
- axi_bid, in, ID_WIDTH; axi_bresp, in, 2; axi_bvalid, in, 1; axi_bready, out, 1.
- busy, out, 1, state != IDLE or FIFO not empty.
- resp_err, out, 1, one-cycle pulse on bresp != OKAY.
- frame_short, out, 1, one-cycle pulse when sof arrives before FRAME_BEATS beats of the previous frame.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clock. All outputs 0 except constants (awid, awsize, awburst, wstrb). State IDLE, FIFO empty, frame beat count 0, next address 0.
- Input side:
  - in_ready = !fifo_full && !(in_sof && (state != IDLE || fifo_count != 0)).
  - An sof beat is accepted only when the FIFO is empty and the FSM is IDLE, i.e. after the previous frame is fully flushed.
  - On accepted sof: next_addr <= frame_base_addr; frame_cnt <= 1; frame_short pulses if the previous frame_cnt was not 0 and not FRAME_BEATS.
  - Non-sof beats increment frame_cnt, saturating at FRAME_BEATS.
  - Non-sof beats arriving before the first sof are accepted and written from address 0.
- FSM states IDLE, AW, W, B:
  - IDLE -> AW when fifo_count ≥ BURST_LEN (len = BURST_LEN); or when a tail condition holds with fifo_count > 0 (len = fifo_count, capped at BURST_LEN).
  - Tail condition: frame_cnt == FRAME_BEATS and all beats are accepted, or a pending sof is blocked at the input (in_valid && in_sof && !in_ready).
  - In AW: awaddr = next_addr, awlen = len-1, both latched on entry. awvalid is registered, high from the first AW cycle and held until awready. AW -> W on awvalid && awready.
  - In W: wvalid = fifo_not_empty (FWFT head); wdata = FIFO head; FIFO pops on wvalid && wready.
  - Beat counter: wlast = (beat_cnt == awlen). W -> B on wvalid && wready && wlast.
  - In B: bready = 1. B -> IDLE on bvalid. next_addr += len*ADDR_INC, wrapping modulo 2^ADDR_WIDTH. resp_err pulses if bresp != 2'b00.
- A new AW is issued only after the B response: one outstanding transaction, which the bridge requires.
- Burst data is already resident in the FIFO before AW is issued, so W never starves mid-burst. A gap in wvalid is still legal if the FIFO is unexpectedly empty.
- Simultaneous FIFO push and pop in one cycle: count unchanged.
- Full FIFO: in_ready = 0. No data is lost.
- Reset mid-burst: everything returns to reset values immediately. The partial burst is abandoned; the bridge is reset by the same rst.

Decomposition:
- Shared package axi_wr_pkg: state enum (IDLE, AW, W, B), AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, function for awsize from DATA_WIDTH.
- One sub-module: wr_burst_fifo, a synchronous FWFT FIFO with count, full and empty outputs, reset by rst.

Test Plan:
1. FRAME_BEATS=128, BURST_LEN=64, base=0x1000, continuous stream, awready/wready always high -> two bursts: awaddr 0x1000 and 0x1200, awlen 63 each; wlast on beat 64 of each; busy drops after 2nd B.
2. 100-beat frame then sof with base=0x2000 -> bursts awlen 63 @0x1000 and awlen 35 @0x1200. frame_short pulses once. The sof beat is stalled (in_ready=0) until the 2nd B, then accepted; the next burst starts at 0x2000.
3. awready delayed 5 cycles -> awvalid, awaddr and awlen held stable for all 6 cycles; no W beat before the handshake.
4. wready toggling 50% with a random pattern -> exactly 64 beats in order, data matches input, wlast only on the 64th accepted beat.
5. bresp=2'b10 on the first burst -> resp_err one-cycle pulse; the second burst proceeds normally at the next address.
6. rst asserted mid-W at beat 20 -> next cycle: awvalid/wvalid/bready=0, in_ready=1, busy=0. A fresh frame afterwards writes from its new base.
